// File: rtl/tile_frame_buffer_pkg.sv
// Purpose: shared grid geometry, tile codes, clear-sweep state encoding and cell address helper.
// Latency: n/a (declarations and a pure combinational function only).
// Backpressure: n/a.
package tile_frame_buffer_pkg;

    localparam int GRID_W     = 160;
    localparam int GRID_H     = 120;
    localparam int GRID_CELLS = 19200;
    localparam int ADDR_W     = 15;
    localparam int CELL_PIX   = 4;

    localparam logic [1:0] TILE_BG     = 2'd0;
    localparam logic [1:0] TILE_BODY   = 2'd1;
    localparam logic [1:0] TILE_HEAD   = 2'd2;
    localparam logic [1:0] TILE_TARGET = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Y*160 + X as two shifts and an add. Worst case for any 8-bit X and
    // 7-bit Y is 127*160+255 = 20575, which still fits in 15 bits.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] x, input logic [6:0] y);
        logic [ADDR_W-1:0] yy;
        yy = {8'd0, y};
        return (yy << 7) + (yy << 5) + {7'd0, x};
    endfunction

endpackage

// File: rtl/tile_frame_buffer_ram.sv
// Purpose: simple dual-port 2-bit tile store; one write port, one registered read port.
// Latency: read data valid 1 cycle after rd_addr; same-address read/write returns old data.
// Backpressure: none; both ports accept every cycle. Out-of-range addresses write nothing, read 0.
// Ports: clk; wr_en/wr_addr/wr_dat write port; rd_addr in, rd_dat registered out.
module tile_ram #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_dat
);

    logic [1:0] mem [DEPTH];

    // Write and read in one block with non-blocking updates: a read of the
    // address being written sees the previous content.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_dat;
        end
        if (int'(rd_addr) < DEPTH) begin
            rd_dat <= mem[rd_addr];
        end else begin
            rd_dat <= 2'd0;
        end
    end

endmodule

// File: rtl/tile_frame_buffer.sv
// Purpose: 160x120 2-bit tile frame buffer with game write/read ports, VGA colour path and clear sweep.
// Latency: game read 1 cycle (rd_en -> rd_valid); video 2 cycles (addrh/addrv -> colour).
// Backpressure: wr_ready = !busy; writes stall for the 19200-cycle clear sweep, reads never stall.
// Ports: clk, reset (sync, active-high); clear_req/busy; wr_valid/wr_ready/wr_x/wr_y/wr_code;
//        rd_en/rd_x/rd_y -> rd_valid/rd_code; addrh/addrv -> colour (RGB332).
module tile_frame_buffer
    import tile_frame_buffer_pkg::*;
#(
    parameter logic [7:0] COLOUR_BG     = 8'h00,
    parameter logic [7:0] COLOUR_BODY   = 8'h1C,
    parameter logic [7:0] COLOUR_HEAD   = 8'hFC,
    parameter logic [7:0] COLOUR_TARGET = 8'hE0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_req,
    output logic       busy,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_x,
    input  logic [6:0] wr_y,
    input  logic [1:0] wr_code,
    input  logic       rd_en,
    input  logic [7:0] rd_x,
    input  logic [6:0] rd_y,
    output logic       rd_valid,
    output logic [1:0] rd_code,
    input  logic [9:0] addrh,
    input  logic [8:0] addrv,
    output logic [7:0] colour
);

    state_t              state;
    logic [ADDR_W-1:0]   clr_addr;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [1:0]          ram_wdat;

    logic                wr_in_range;
    logic                rd_in_range;
    logic [ADDR_W-1:0]   game_raddr;
    logic [1:0]          game_rdat;
    logic                rd_zero_q;

    logic [ADDR_W-1:0]   vid_raddr;
    logic [1:0]          vid_rdat;
    logic                pix_blank;
    logic                vid_blank_q;
    logic                vid_bg_q;

    assign busy     = (state == ST_CLEAR);
    assign wr_ready = !busy;

    assign wr_in_range = (int'(wr_x) < GRID_W) && (int'(wr_y) < GRID_H);
    assign rd_in_range = (int'(rd_x) < GRID_W) && (int'(rd_y) < GRID_H);

    // Shared write port for both RAM copies: the sweep owns it while busy,
    // otherwise an accepted in-range game write uses it.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_addr;
        ram_wdat  = TILE_BG;
        if (busy) begin
            ram_we = 1'b1;
        end else if (wr_valid && wr_in_range) begin
            ram_we    = 1'b1;
            ram_waddr = cell_addr(wr_x, wr_y);
            ram_wdat  = wr_code;
        end
    end

    // Clear sweep. Reset lands in CLEAR so the RAM is initialised on power-up;
    // a clear_req while sweeping is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr == ADDR_W'(GRID_CELLS - 1)) begin
                        state    <= ST_IDLE;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    clr_addr <= '0;
                end
            endcase
        end
    end

    // Game read: address goes straight into the RAM's registered read, so the
    // response lines up with rd_valid one cycle later.
    assign game_raddr = cell_addr(rd_x, rd_y);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid  <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            rd_valid  <= rd_en;
            rd_zero_q <= busy || !rd_in_range;
        end
    end

    assign rd_code = (rd_valid && !rd_zero_q) ? game_rdat : TILE_BG;

    // Video: the RAM's read register is the address stage; the blank/busy
    // flags ride alongside it, then the palette register forms the second stage.
    assign vid_raddr = cell_addr(addrh[9:2], addrv[8:2]);
    assign pix_blank = (int'(addrh) >= GRID_W * CELL_PIX) || (int'(addrv) >= GRID_H * CELL_PIX);

    always_ff @(posedge clk) begin
        if (reset) begin
            vid_blank_q <= 1'b0;
            vid_bg_q    <= 1'b0;
            colour      <= 8'h00;
        end else begin
            vid_blank_q <= pix_blank;
            vid_bg_q    <= busy;
            if (vid_blank_q) begin
                colour <= 8'h00;
            end else if (vid_bg_q) begin
                colour <= COLOUR_BG;
            end else begin
                case (vid_rdat)
                    TILE_BODY:   colour <= COLOUR_BODY;
                    TILE_HEAD:   colour <= COLOUR_HEAD;
                    TILE_TARGET: colour <= COLOUR_TARGET;
                    default:     colour <= COLOUR_BG;
                endcase
            end
        end
    end

    // Two mirrored copies so video and game reads never contend for a port.
    tile_ram #(.DEPTH(GRID_CELLS), .AW(ADDR_W)) u_ram_video (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_dat  (ram_wdat),
        .rd_addr (vid_raddr),
        .rd_dat  (vid_rdat)
    );

    tile_ram #(.DEPTH(GRID_CELLS), .AW(ADDR_W)) u_ram_game (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_dat  (ram_wdat),
        .rd_addr (game_raddr),
        .rd_dat  (game_rdat)
    );

endmodule

// File: tb/tb_tile_frame_buffer.sv
// Purpose: self-checking bench for tile_frame_buffer using a directed vector table plus sequences.
// Latency: checks 1-cycle game reads and 2-cycle video colour.
// Backpressure: checks wr_ready low for the whole clear sweep.
module tb_tile_frame_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear_req = 1'b0;
    logic       busy;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_x = '0;
    logic [6:0] wr_y = '0;
    logic [1:0] wr_code = '0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_x = '0;
    logic [6:0] rd_y = '0;
    logic       rd_valid;
    logic [1:0] rd_code;
    logic [9:0] addrh = '0;
    logic [8:0] addrv = '0;
    logic [7:0] colour;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tile_frame_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_code   (wr_code),
        .rd_en     (rd_en),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_valid  (rd_valid),
        .rd_code   (rd_code),
        .addrh     (addrh),
        .addrv     (addrv),
        .colour    (colour)
    );

    typedef struct {
        logic       wr;
        logic [7:0] x;
        logic [6:0] y;
        logic [1:0] code;
        logic [7:0] rx;
        logic [6:0] ry;
        logic [1:0] exp_rd;
        logic [9:0] h;
        logic [8:0] v;
        logic [7:0] exp_col;
    } vec_t;

    vec_t vecs [11];

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] x, input logic [6:0] y, input logic [1:0] code);
        wr_valid = 1'b1;
        wr_x = x;
        wr_y = y;
        wr_code = code;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [7:0] x, input logic [6:0] y,
                           input logic [1:0] exp);
        rd_en = 1'b1;
        rd_x = x;
        rd_y = y;
        tick();
        rd_en = 1'b0;
        check({name, "_rd_valid"}, 32'(rd_valid), 32'd1);
        check({name, "_rd_code"}, 32'(rd_code), 32'(exp));
    endtask

    task automatic do_pixel(input string name, input logic [9:0] h, input logic [8:0] v,
                            input logic [7:0] exp);
        addrh = h;
        addrv = v;
        tick();
        tick();
        check({name, "_colour"}, 32'(colour), 32'(exp));
    endtask

    // Counts busy cycles from the current point; optionally pulses clear_req
    // at cycle 5000 to show it does not extend the sweep.
    task automatic count_busy(input string name, input bit poke_clear);
        int  cnt;
        bit  wr_bad;
        cnt = 0;
        wr_bad = 1'b0;
        while (busy && cnt < 20000) begin
            if (wr_ready) wr_bad = 1'b1;
            if (poke_clear && cnt == 5000) clear_req = 1'b1;
            tick();
            clear_req = 1'b0;
            cnt++;
        end
        check({name, "_busy_cycles"}, 32'(cnt), 32'd19200);
        check({name, "_wr_ready_low"}, 32'(wr_bad), 32'd0);
        check({name, "_wr_ready_after"}, 32'(wr_ready), 32'd1);
    endtask

    initial begin
        //         wr    x      y      code  rx     ry     exp   h        v       colour
        vecs[0]  = '{1'b1, 8'd5,   7'd3,   2'd3, 8'd5,   7'd3,   2'd3, 10'd21,   9'd13,  8'hE0};
        vecs[1]  = '{1'b0, 8'd0,   7'd0,   2'd0, 8'd6,   7'd3,   2'd0, 10'd24,   9'd13,  8'h00};
        vecs[2]  = '{1'b1, 8'd0,   7'd0,   2'd2, 8'd0,   7'd0,   2'd2, 10'd0,    9'd0,   8'hFC};
        vecs[3]  = '{1'b0, 8'd0,   7'd0,   2'd0, 8'd0,   7'd0,   2'd2, 10'd640,  9'd0,   8'h00};
        vecs[4]  = '{1'b1, 8'd10,  7'd20,  2'd1, 8'd10,  7'd20,  2'd1, 10'd43,   9'd83,  8'h1C};
        vecs[5]  = '{1'b1, 8'd160, 7'd0,   2'd2, 8'd0,   7'd1,   2'd0, 10'd0,    9'd4,   8'h00};
        vecs[6]  = '{1'b0, 8'd0,   7'd0,   2'd0, 8'd160, 7'd0,   2'd0, 10'd3,    9'd480, 8'h00};
        vecs[7]  = '{1'b1, 8'd159, 7'd119, 2'd3, 8'd159, 7'd119, 2'd3, 10'd639,  9'd479, 8'hE0};
        vecs[8]  = '{1'b1, 8'd5,   7'd3,   2'd0, 8'd5,   7'd3,   2'd0, 10'd22,   9'd14,  8'h00};
        vecs[9]  = '{1'b1, 8'd0,   7'd0,   2'd1, 8'd0,   7'd0,   2'd1, 10'd1,    9'd2,   8'h1C};
        vecs[10] = '{1'b1, 8'd200, 7'd127, 2'd2, 8'd159, 7'd119, 2'd3, 10'd1023, 9'd511, 8'h00};

        // Reset state and power-up sweep.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_code", 32'(rd_code), 32'd0);
        check("rst_colour", 32'(colour), 32'd0);
        count_busy("init", 1'b0);

        // Same-cycle write and read of one cell returns old content.
        wr_valid = 1'b1; wr_x = 8'd159; wr_y = 7'd119; wr_code = 2'd1;
        rd_en = 1'b1;    rd_x = 8'd159; rd_y = 7'd119;
        tick();
        wr_valid = 1'b0;
        check("rw_same_valid", 32'(rd_valid), 32'd1);
        check("rw_same_code", 32'(rd_code), 32'd0);
        tick();
        rd_en = 1'b0;
        check("rw_next_valid", 32'(rd_valid), 32'd1);
        check("rw_next_code", 32'(rd_code), 32'd1);
        tick();
        check("rd_valid_drop", 32'(rd_valid), 32'd0);

        // Table of write / read / pixel vectors against the accumulated grid.
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) do_write(vecs[i].x, vecs[i].y, vecs[i].code);
            do_read($sformatf("vec%0d", i), vecs[i].rx, vecs[i].ry, vecs[i].exp_rd);
            do_pixel($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].exp_col);
        end

        // Clear request together with a write: write accepted, then swept.
        check("clr_wr_ready", 32'(wr_ready), 32'd1);
        clear_req = 1'b1;
        do_write(8'd7, 7'd7, 2'd2);
        clear_req = 1'b0;
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_wr_ready_low", 32'(wr_ready), 32'd0);
        do_read("busy", 8'd10, 7'd20, 2'd0);
        do_pixel("busy", 10'd43, 10'd83, 8'h00);
        for (int i = 0; i < 95; i++) tick();
        check("clr_busy_pre_reset", 32'(busy), 32'd1);

        // Reset mid-sweep restarts a full sweep; a mid-sweep clear_req is ignored.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_busy", 32'(busy), 32'd1);
        count_busy("rst2", 1'b1);

        do_read("post_clr_a", 8'd7, 7'd7, 2'd0);
        do_read("post_clr_b", 8'd10, 7'd20, 2'd0);
        do_read("post_clr_c", 8'd159, 7'd119, 2'd0);
        do_pixel("post_clr", 10'd43, 9'd83, 8'h00);
        do_write(8'd10, 7'd20, 2'd2);
        do_pixel("post_wr", 10'd40, 9'd80, 8'hFC);
        do_read("post_wr", 8'd10, 7'd20, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
